// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer
// Description : Parallel-in/serial-out serializer, symbol 0 (LSBs) first.
//               Optional macro PISO_SERIALIZER_B2B_EN enables back-to-back
//               loading on the final beat of a word.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_WORDS  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_WORDS*DATA_WIDTH-1:0] in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last
);

  localparam int                TOTAL_W  = NUM_WORDS * DATA_WIDTH;
  localparam int                CNT_W    = $clog2(NUM_WORDS);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_WORDS - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [TOTAL_W-1:0] buf_q,   buf_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               w_load;
  logic               w_beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    count_d = count_q;
    w_load  = in_valid & in_ready;
    w_beat  = out_valid & out_ready;
    case (state_q)
      S_IDLE: begin
        if (w_load) begin
          buf_d   = in_data;
          count_d = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_beat) begin
          if (out_last) begin
            // A load here is only possible when back-to-back loading is built in.
            if (w_load) begin
              buf_d   = in_data;
              count_d = '0;
            end else begin
              state_d = S_IDLE;
              buf_d   = '0;
              count_d = '0;
            end
          end else begin
            buf_d   = buf_q >> DATA_WIDTH;
            count_d = count_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_data  = buf_q[DATA_WIDTH-1:0];
    out_valid = (state_q == S_SHIFT);
    out_last  = out_valid && (count_q == LAST_CNT);
`ifdef PISO_SERIALIZER_B2B_EN
    in_ready  = (state_q == S_IDLE) || (out_last && out_ready);
`else
    in_ready  = (state_q == S_IDLE);
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_serializer
// Description : Scoreboard bench for piso_serializer (DATA_WIDTH=8, NUM_WORDS=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  int          checks = 0;
  int          errors = 0;
  logic [8:0]  sb[$];
  logic [8:0]  exp_s;

`ifdef PISO_SERIALIZER_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  piso_serializer #(.DATA_WIDTH(8), .NUM_WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic v, input logic [31:0] d, input logic r);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({out_valid, out_last, in_ready, out_data} !== {1'b0, 1'b0, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b last=%b ready=%b data=%h, required 0 0 1 00",
               out_valid, out_last, in_ready, out_data);
    end
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got valid=%b ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_basic;
    for (int c = 0; c <= 5; c++) begin
      cyc(c == 0, 32'h44332211, 1'b1);
      if (c >= 1 && c <= 4) begin
        checks++;
        if (in_ready !== (B2B && c == 4) || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL basic_ready c%0d: got ready=%b valid=%b, required ready=%b valid=1",
                   c, in_ready, out_valid, (B2B && c == 4));
        end
      end
      if (c == 5) begin
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL basic_idle: got ready=%b valid=%b, required 1 0", in_ready, out_valid);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL basic_beat: got unexpected data=%h, required no output", out_data);
        end else begin
          exp_s = sb.pop_front();
          if ({out_last, out_data} !== exp_s) begin
            errors++;
            $display("FAIL basic_beat: got last=%b data=%h, required last=%b data=%h",
                     out_last, out_data, exp_s[8], exp_s[7:0]);
          end
        end
      end
      if (in_valid && in_ready)
        for (int k = 0; k < 4; k++) sb.push_back({k == 3, in_data[k*8 +: 8]});
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL basic_drain: got %0d symbols left, required 0", sb.size());
    end
  endtask

  task automatic test_backpressure;
    for (int c = 0; c <= 7; c++) begin
      cyc(c == 0, 32'h44332211, !(c == 2 || c == 3));
      if (c == 2 || c == 3) begin
        checks++;
        if (out_data !== 8'h22 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL bp_hold c%0d: got data=%h valid=%b, required 22 1", c, out_data, out_valid);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL bp_beat: got unexpected data=%h, required no output", out_data);
        end else begin
          exp_s = sb.pop_front();
          if ({out_last, out_data} !== exp_s) begin
            errors++;
            $display("FAIL bp_beat: got last=%b data=%h, required last=%b data=%h",
                     out_last, out_data, exp_s[8], exp_s[7:0]);
          end
        end
      end
      if (in_valid && in_ready)
        for (int k = 0; k < 4; k++) sb.push_back({k == 3, in_data[k*8 +: 8]});
    end
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got %0d left valid=%b, required 0 left valid=0", sb.size(), out_valid);
    end
  endtask

  task automatic test_back_to_back;
    int loads = 0;
    int t44 = -1;
    int t55 = -1;
    for (int c = 0; c < 14; c++) begin
      cyc(loads < 2, (loads == 0) ? 32'h44332211 : 32'h88776655, 1'b1);
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL b2b_beat: got unexpected data=%h, required no output", out_data);
        end else begin
          exp_s = sb.pop_front();
          if ({out_last, out_data} !== exp_s) begin
            errors++;
            $display("FAIL b2b_beat: got last=%b data=%h, required last=%b data=%h",
                     out_last, out_data, exp_s[8], exp_s[7:0]);
          end
          if (exp_s == 9'h144 && t44 < 0) t44 = c;
          if (exp_s == 9'h055 && t55 < 0) t55 = c;
        end
      end
      if (in_valid && in_ready) begin
        loads++;
        for (int k = 0; k < 4; k++) sb.push_back({k == 3, in_data[k*8 +: 8]});
      end
    end
    checks++;
    if (t44 < 0 || t55 < 0 || (t55 - t44) != (B2B ? 1 : 2)) begin
      errors++;
      $display("FAIL b2b_gap: got t44=%0d t55=%0d, required gap %0d", t44, t55, B2B ? 1 : 2);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: got %0d symbols left, required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid_word;
    bit first = 1'b1;
    for (int c = 0; c <= 2; c++) begin
      cyc(c == 0, 32'h44332211, 1'b1);
      if (out_valid && out_ready) begin
        checks++;
        exp_s = (sb.size() != 0) ? sb.pop_front() : 9'h1FF;
        if ({out_last, out_data} !== exp_s) begin
          errors++;
          $display("FAIL rst_pre_beat: got last=%b data=%h, required last=%b data=%h",
                   out_last, out_data, exp_s[8], exp_s[7:0]);
        end
      end
      if (in_valid && in_ready)
        for (int k = 0; k < 4; k++) sb.push_back({k == 3, in_data[k*8 +: 8]});
    end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    sb.delete();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_word: got valid=%b ready=%b last=%b data=%h, required 0 1 0 00",
               out_valid, in_ready, out_last, out_data);
    end
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c <= 5; c++) begin
      cyc(c == 0, 32'hDDCCBBAA, 1'b1);
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rst_post_beat: got unexpected data=%h, required no output", out_data);
        end else begin
          exp_s = sb.pop_front();
          if ({out_last, out_data} !== exp_s || (first && out_data !== 8'hAA)) begin
            errors++;
            $display("FAIL rst_post_beat: got last=%b data=%h, required last=%b data=%h",
                     out_last, out_data, exp_s[8], exp_s[7:0]);
          end
          first = 1'b0;
        end
      end
      if (in_valid && in_ready)
        for (int k = 0; k < 4; k++) sb.push_back({k == 3, in_data[k*8 +: 8]});
    end
    checks++;
    if (sb.size() != 0 || first) begin
      errors++;
      $display("FAIL rst_post_drain: got %0d left first_pending=%b, required 0 0", sb.size(), first);
    end
  endtask

  task automatic test_ignored_input;
    for (int c = 0; c <= 5; c++) begin
      if (c == 0)      cyc(1'b1, 32'h44332211, 1'b1);
      else if (c <= 3) cyc(1'b1, 32'hFFFFFFFF, 1'b1);
      else             cyc(1'b0, 32'hFFFFFFFF, 1'b1);
      if (c >= 1 && c <= 3) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL ign_ready c%0d: got %b, required 0", c, in_ready);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL ign_beat: got unexpected data=%h, required no output", out_data);
        end else begin
          exp_s = sb.pop_front();
          if ({out_last, out_data} !== exp_s) begin
            errors++;
            $display("FAIL ign_beat: got last=%b data=%h, required last=%b data=%h",
                     out_last, out_data, exp_s[8], exp_s[7:0]);
          end
        end
      end
      if (in_valid && in_ready)
        for (int k = 0; k < 4; k++) sb.push_back({k == 3, in_data[k*8 +: 8]});
    end
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ign_drain: got %0d left valid=%b, required 0 left valid=0", sb.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_word();
    test_ignored_input();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
